cv32e40p_discontinuity_monitor: RTL and testbench

Watchdog that sits directly downstream of the discontinuity-insertion stage, on the instruction path into the decoder. It classifies every instruction it accepts as control-flow (discontinuity) or not, and counts how many consecutive non-discontinuity instructions have passed. If the count reaches the window length, it raises a sticky alarm. It also exports run-length and discontinuity statistics for verification and hardening evaluation.

---
 rtl/cv32e40p_disc_pkg.sv | 42 ++++
 rtl/cv32e40p_disc_decode.sv | 11 +
 rtl/cv32e40p_discontinuity_monitor.sv | 116 +++++++++++
 tb/tb_cv32e40p_discontinuity_monitor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_disc_pkg.sv
// Shared definitions for discontinuity insertion and monitoring: encodings,
// monitor state enum and the control-flow classifier.
package cv32e40p_disc_pkg;

    // 32-bit major opcodes that redirect the PC
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [2:0] JALR_FUNCT3   = 3'b000;

    // Quadrant 1 compressed control flow: c.jal, c.j, c.beqz, c.bnez
    localparam logic [2:0] C1_F3_JAL  = 3'b001;
    localparam logic [2:0] C1_F3_J    = 3'b101;
    localparam logic [2:0] C1_F3_BEQZ = 3'b110;
    localparam logic [2:0] C1_F3_BNEZ = 3'b111;

    // Quadrant 2 compressed c.jr / c.jalr share funct3 100 with rs2 == 0
    localparam logic [2:0] C2_F3_JR = 3'b100;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_RUN      = 2'b01,
        ST_ALARM    = 2'b10
    } disc_mon_state_e;

    // True when the word is any compressed or 32-bit jump/branch
    function automatic logic is_disc_instr(input logic [31:0] instr);
        logic r;
        r = 1'b0;
        case (instr[1:0])
            2'b01: r = (instr[15:13] == C1_F3_JAL)  || (instr[15:13] == C1_F3_J) ||
                       (instr[15:13] == C1_F3_BEQZ) || (instr[15:13] == C1_F3_BNEZ);
            2'b10: r = (instr[15:13] == C2_F3_JR) && (instr[6:2] == 5'b0) &&
                       (instr[11:7] != 5'b0);
            2'b11: r = (instr[6:0] == OPCODE_BRANCH) || (instr[6:0] == OPCODE_JAL) ||
                       ((instr[6:0] == OPCODE_JALR) && (instr[14:12] == JALR_FUNCT3));
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cv32e40p_disc_decode.sv
// Combinational classifier: flags control-flow instructions.
module cv32e40p_disc_decode
    import cv32e40p_disc_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        is_disc_o
);

    assign is_disc_o = is_disc_instr(instr_i);

endmodule

// File: rtl/cv32e40p_discontinuity_monitor.sv
// Watchdog counting consecutive non-control-flow instructions; raises a
// sticky alarm once a run reaches WWDL and exports run/discontinuity stats.
module cv32e40p_discontinuity_monitor
    import cv32e40p_disc_pkg::*;
#(
    parameter int WWDL      = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_i,
    input  logic                         instr_valid_i,
    input  logic [31:0]                  instr_i,
    input  logic                         flush_i,
    input  logic                         clear_i,
    output logic                         alarm_o,
    output logic                         alarm_pulse_o,
    output logic [$clog2(WWDL+1)-1:0]    run_o,
    output logic [CNT_WIDTH-1:0]         disc_cnt_o,
    output logic [$clog2(WWDL+1)-1:0]    max_run_o
);

    localparam int RUN_W = $clog2(WWDL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WWDL);
    localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(WWDL - 1);

    disc_mon_state_e      r_state;
    logic [RUN_W-1:0]     r_run;
    logic [RUN_W-1:0]     r_max_run;
    logic [CNT_WIDTH-1:0] r_disc_cnt;
    logic                 r_alarm;
    logic                 r_pulse;

    logic                 w_is_disc;
    logic                 w_accept;
    logic                 w_count;
    logic                 w_violate;
    logic [RUN_W-1:0]     w_run_inc;
    logic [RUN_W-1:0]     w_run_nxt;

    cv32e40p_disc_decode u_decode (
        .instr_i   (instr_i),
        .is_disc_o (w_is_disc)
    );

    // Bubbles (all-zero words) are never counted
    assign w_accept  = instr_valid_i && (instr_i != 32'h0);
    // Run increment saturates at WWDL so ALARM can keep counting
    assign w_run_inc = (r_run >= RUN_PRE) ? RUN_MAX : r_run + 1'b1;

    // Next run length; disable, clear and flush all restart the run and
    // swallow any instruction accepted in the same cycle
    always_comb begin
        w_count   = 1'b0;
        w_run_nxt = r_run;
        if (!enable_i || (r_state == ST_DISABLED) || clear_i || flush_i) begin
            w_run_nxt = '0;
        end else if (w_accept) begin
            w_count   = 1'b1;
            w_run_nxt = w_is_disc ? '0 : w_run_inc;
        end
    end

    assign w_violate = w_count && !w_is_disc && (r_state == ST_RUN) && (w_run_inc == RUN_MAX);

    // Monitor FSM with registered alarm, pulse and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_DISABLED;
            r_run      <= '0;
            r_max_run  <= '0;
            r_disc_cnt <= '0;
            r_alarm    <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_run   <= w_run_nxt;
            r_pulse <= 1'b0;
            if (w_run_nxt > r_max_run)
                r_max_run <= w_run_nxt;
            if (w_count && w_is_disc && (r_disc_cnt != '1))
                r_disc_cnt <= r_disc_cnt + 1'b1;
            if (!enable_i) begin
                r_state <= ST_DISABLED;
                r_alarm <= 1'b0;
            end else begin
                case (r_state)
                    ST_DISABLED: r_state <= ST_RUN;
                    ST_RUN: begin
                        if (w_violate) begin
                            r_state <= ST_ALARM;
                            r_alarm <= 1'b1;
                            r_pulse <= 1'b1;
                        end
                    end
                    ST_ALARM: begin
                        if (clear_i) begin
                            r_state <= ST_RUN;
                            r_alarm <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_DISABLED;
                        r_alarm <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign alarm_o       = r_alarm;
    assign alarm_pulse_o = r_pulse;
    assign run_o         = r_run;
    assign disc_cnt_o    = r_disc_cnt;
    assign max_run_o     = r_max_run;

endmodule

// File: tb/tb_cv32e40p_discontinuity_monitor.sv
// Bench: directed scenarios plus random traffic against a behavioural model.
module tb_cv32e40p_discontinuity_monitor;

    localparam int WWDL = 4;
    localparam int RW   = $clog2(WWDL + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        vld = 1'b0;
    logic [31:0] ins = 32'h0;
    logic        fl = 1'b0;
    logic        cl = 1'b0;

    logic          a_alarm, a_pulse, b_alarm, b_pulse;
    logic [RW-1:0] a_run, a_max, b_run, b_max;
    logic [15:0]   a_disc;
    logic [1:0]    b_disc;

    int n_chk = 0;
    int n_err = 0;

    // model state
    bit m_dis = 1'b1;
    bit m_alarm = 1'b0;
    bit m_pulse = 1'b0;
    int m_run = 0;
    int m_max = 0;
    int m_disc = 0;

    always #5 clk = ~clk;

    cv32e40p_discontinuity_monitor #(.WWDL(WWDL), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable_i(en), .instr_valid_i(vld), .instr_i(ins),
        .flush_i(fl), .clear_i(cl), .alarm_o(a_alarm), .alarm_pulse_o(a_pulse),
        .run_o(a_run), .disc_cnt_o(a_disc), .max_run_o(a_max)
    );

    cv32e40p_discontinuity_monitor #(.WWDL(WWDL), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .enable_i(en), .instr_valid_i(vld), .instr_i(ins),
        .flush_i(fl), .clear_i(cl), .alarm_o(b_alarm), .alarm_pulse_o(b_pulse),
        .run_o(b_run), .disc_cnt_o(b_disc), .max_run_o(b_max)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Independent restatement of the control-flow encodings
    function automatic bit ref_disc(input logic [31:0] w);
        int q, f3, op;
        q  = int'(w[1:0]);
        f3 = int'(w[15:13]);
        op = int'(w[6:0]);
        if (q == 1) return (f3 == 1) || (f3 >= 5);
        if (q == 2) return (f3 == 4) && (w[6:2] == 5'd0) && (w[11:7] != 5'd0);
        if (q == 3) return (op == 'h63) || (op == 'h6f) || ((op == 'h67) && (w[14:12] == 3'd0));
        return 1'b0;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_dis = 1'b1; m_alarm = 1'b0; m_pulse = 1'b0;
            m_run = 0; m_max = 0; m_disc = 0;
        end else begin
            m_pulse = 1'b0;
            if (!en) begin
                m_dis = 1'b1; m_alarm = 1'b0; m_run = 0;
            end else if (m_dis) begin
                m_dis = 1'b0; m_run = 0;
            end else if (cl) begin
                m_alarm = 1'b0; m_run = 0;
            end else if (fl) begin
                m_run = 0;
            end else if (vld && ins != 32'h0) begin
                if (ref_disc(ins)) begin
                    m_run = 0;
                    m_disc++;
                end else if (m_run + 1 >= WWDL) begin
                    m_run = WWDL;
                    if (!m_alarm) begin
                        m_alarm = 1'b1;
                        m_pulse = 1'b1;
                    end
                end else begin
                    m_run++;
                end
            end
            if (m_run > m_max) m_max = m_run;
        end
    endtask

    // Drive one cycle of inputs, advance the model, return at the next negedge
    task automatic step(input bit e, input bit v, input logic [31:0] w,
                        input bit f, input bit c, input bit r);
        en = e; vld = v; ins = w; fl = f; cl = c; rst = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Every cycle: both DUT instances against the model
    always @(negedge clk) begin
        chk("alarm", 32'(a_alarm), 32'(m_alarm));
        chk("pulse", 32'(a_pulse), 32'(m_pulse));
        chk("run", 32'(a_run), m_run);
        chk("max_run", 32'(a_max), m_max);
        chk("disc_cnt", 32'(a_disc), (m_disc > 65535) ? 65535 : m_disc);
        chk("alarm2", 32'(b_alarm), 32'(m_alarm));
        chk("pulse2", 32'(b_pulse), 32'(m_pulse));
        chk("run2", 32'(b_run), m_run);
        chk("disc_cnt2", 32'(b_disc), (m_disc > 3) ? 3 : m_disc);
    end

    localparam logic [31:0] ADDI = 32'h0000_0013;
    localparam logic [31:0] JAL  = 32'h0000_006f;

    logic [31:0] disc_tab [5] = '{32'h0000_a001, 32'h0000_8082, 32'h0000_c101,
                                  32'h0000_0063, 32'h0000_8067};

    initial begin
        logic [31:0] rnd;
        // reset
        step(0, 0, 0, 0, 0, 1);
        chk("lit_reset_alarm", 32'(a_alarm), 0);
        chk("lit_reset_run", 32'(a_run), 0);
        chk("lit_reset_disc", 32'(a_disc), 0);
        // disabled: no counting
        for (int i = 0; i < 20; i++) step(0, 1, ADDI, 0, 0, 0);
        chk("lit_disabled_run", 32'(a_run), 0);
        // enable, then 3 addi and a jal
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step(1, 1, ADDI, 0, 0, 0);
            chk("lit_run_ramp", 32'(a_run), 32'(i));
        end
        step(1, 1, JAL, 0, 0, 0);
        chk("lit_run_jal", 32'(a_run), 0);
        chk("lit_disc_1", 32'(a_disc), 1);
        chk("lit_max_3", 32'(a_max), 3);
        chk("lit_no_alarm", 32'(a_alarm), 0);
        // violation with bubbles interleaved
        for (int i = 0; i < 3; i++) begin
            step(1, 1, ADDI, 0, 0, 0);
            step(1, 1, 32'h0, 0, 0, 0);
        end
        step(1, 1, ADDI, 0, 0, 0);
        chk("lit_pulse_hi", 32'(a_pulse), 1);
        chk("lit_alarm_hi", 32'(a_alarm), 1);
        step(1, 0, 0, 0, 0, 0);
        chk("lit_pulse_lo", 32'(a_pulse), 0);
        chk("lit_alarm_held", 32'(a_alarm), 1);
        step(1, 0, 0, 0, 1, 0);
        chk("lit_clear_alarm", 32'(a_alarm), 0);
        chk("lit_clear_run", 32'(a_run), 0);
        // classification
        for (int i = 0; i < 5; i++) begin
            step(1, 1, ADDI, 0, 0, 0);
            step(1, 1, disc_tab[i], 0, 0, 0);
            chk("lit_class_disc", 32'(a_run), 0);
        end
        step(1, 1, 32'h0000_9067, 0, 0, 0);
        chk("lit_class_jalr001", 32'(a_run), 1);
        step(1, 1, 32'h0000_0001, 0, 0, 0);
        chk("lit_class_cnop", 32'(a_run), 2);
        chk("lit_disc_6", 32'(a_disc), 6);
        // flush with the 3rd addi
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, ADDI, 0, 0, 0);
        step(1, 1, ADDI, 0, 0, 0);
        step(1, 1, ADDI, 1, 0, 0);
        chk("lit_flush_run", 32'(a_run), 0);
        chk("lit_flush_alarm", 32'(a_alarm), 0);
        // clear with violating accept
        for (int i = 0; i < 3; i++) step(1, 1, ADDI, 0, 0, 0);
        step(1, 1, ADDI, 0, 1, 0);
        chk("lit_clrwin_pulse", 32'(a_pulse), 0);
        chk("lit_clrwin_alarm", 32'(a_alarm), 0);
        // reset during alarm
        for (int i = 0; i < 4; i++) step(1, 1, ADDI, 0, 0, 0);
        chk("lit_alarm_again", 32'(a_alarm), 1);
        step(1, 1, ADDI, 0, 0, 1);
        chk("lit_rst_alarm", 32'(a_alarm), 0);
        chk("lit_rst_max", 32'(a_max), 0);
        chk("lit_rst_disc", 32'(a_disc), 0);
        // saturation
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, JAL, 0, 0, 0);
        chk("lit_sat_disc2", 32'(b_disc), 3);
        chk("lit_sat_disc16", 32'(a_disc), 5);
        for (int i = 0; i < 4; i++) step(1, 1, ADDI, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, ADDI, 0, 0, 0);
            chk("lit_sat_run", 32'(a_run), 4);
            chk("lit_sat_nopulse", 32'(a_pulse), 0);
        end
        // random traffic
        for (int n = 0; n < 4000; n++) begin
            rnd = $urandom;
            case ($urandom_range(0, 7))
                0: ins = 32'h0;
                1, 2: ins = ADDI;
                3: ins = disc_tab[$urandom_range(0, 4)];
                4: ins = {rnd[31:7], 7'b1100111};
                5: ins = {16'h0, rnd[15:0]};
                default: ins = rnd;
            endcase
            step($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 8, ins,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 199) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
